// File: rtl/grf_write_driver_pkg.sv
// grf_write_driver_pkg: shared widths, register-zero constant and write-request struct
package grf_write_driver_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;
endpackage

// File: rtl/grf_write_driver_if.sv
// grf_write_driver_if: pipeline/MDU request side and GRF write port of the write driver
interface grf_write_driver_if;
  import grf_write_driver_pkg::*;
  logic              a_valid;
  logic [REG_W-1:0]  a_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] a_pc;
  logic              b_valid;
  logic              b_ready;
  logic [REG_W-1:0]  b_addr;
  logic [DATA_W-1:0] b_data;
  logic [DATA_W-1:0] b_pc;
  logic              WE;
  logic [REG_W-1:0]  A3;
  logic [DATA_W-1:0] WD;
  logic [DATA_W-1:0] PC;
  logic [31:0]       pend_mask;
  logic              starve_req;
  modport master (
    output a_valid, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
    input  b_ready, WE, A3, WD, PC, pend_mask, starve_req
  );
  modport slave (
    input  a_valid, a_addr, a_data, a_pc, b_valid, b_addr, b_data, b_pc,
    output b_ready, WE, A3, WD, PC, pend_mask, starve_req
  );
endinterface

// File: rtl/grf_write_driver_wb_fifo.sv
// grf_write_driver_wb_fifo: MDU result queue with per-entry valid bits and WAW squash by address
module grf_write_driver_wb_fifo
  import grf_write_driver_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  input  logic             squash_en,
  input  logic [REG_W-1:0] squash_addr,
  output logic             full,
  output logic             empty,
  output logic             head_valid,
  output wb_req_t          head,
  output logic [DEPTH-1:0] ent_valid,
  output logic [REG_W-1:0] ent_addr [DEPTH]
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  assign full       = cnt_q == (AW+1)'(DEPTH);
  assign empty      = cnt_q == '0;
  assign head       = mem_q[rd_q];
  assign head_valid = vld_q[rd_q];
  assign ent_valid  = vld_q;
  for (genvar g = 0; g < DEPTH; g++) begin : g_addr
    assign ent_addr[g] = mem_q[g].addr;
  end
  // squash before push: a same-cycle push is younger than the A write
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (squash_en && mem_q[i].addr == squash_addr) vld_d[i] = 1'b0;
    if (pop) vld_d[rd_q] = 1'b0;
    if (push) vld_d[wr_q] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= pop ? rd_q + 1'b1 : rd_q;
      wr_q  <= push ? wr_q + 1'b1 : wr_q;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_req;
  end
endmodule

// File: rtl/grf_write_driver.sv
// grf_write_driver: merges pipeline (A) and MDU (B) results onto the single GRF write port
module grf_write_driver
  import grf_write_driver_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  grf_write_driver_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 2);
  logic             a_go, push, pop, issue_b, full, empty, head_valid;
  logic             we_d, we_q, starve_d, starve_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  wb_req_t          a_req, b_req, head, out_d, out_q;
  logic [DEPTH-1:0] ent_valid;
  logic [REG_W-1:0] ent_addr [DEPTH];
  logic [31:0]      pend;
  assign a_req = '{bus.a_addr, bus.a_data, bus.a_pc};
  assign b_req = '{bus.b_addr, bus.b_data, bus.b_pc};
  grf_write_driver_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_req   (b_req),
    .pop        (pop),
    .squash_en  (a_go),
    .squash_addr(bus.a_addr),
    .full       (full),
    .empty      (empty),
    .head_valid (head_valid),
    .head       (head),
    .ent_valid  (ent_valid),
    .ent_addr   (ent_addr)
  );
  // b_ready uses start-of-cycle occupancy, so a full FIFO never takes a push even while popping
  always_comb begin
    a_go     = bus.a_valid && bus.a_addr != REG_ZERO;
    push     = bus.b_valid && !full && bus.b_addr != REG_ZERO;
    pop      = !a_go && !empty;
    issue_b  = pop && head_valid;
    we_d     = a_go || issue_b;
    out_d    = a_go ? a_req : issue_b ? head : out_q;
    cnt_d    = pop ? '0 : (full && a_go && cnt_q < CW'(STARVE_LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    starve_d = cnt_d >= CW'(STARVE_LIMIT);
  end
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[i]) pend[ent_addr[i]] = 1'b1;
    pend[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      out_q    <= '0;
      cnt_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      we_q     <= we_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end
  assign bus.b_ready    = !full;
  assign bus.WE         = we_q;
  assign bus.A3         = out_q.addr;
  assign bus.WD         = out_q.data;
  assign bus.PC         = out_q.pc;
  assign bus.pend_mask  = pend;
  assign bus.starve_req = starve_q;
endmodule

// File: tb/tb_grf_write_driver.sv
// tb_grf_write_driver: directed vectors with hand-computed expectations for grf_write_driver
module tb_grf_write_driver;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_miss = 0;
  grf_write_driver_if bus ();
  grf_write_driver #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv_a(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic [31:0] p);
    bus.a_valid = v; bus.a_addr = ad; bus.a_data = d; bus.a_pc = p;
  endtask
  task automatic drv_b(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic [31:0] p);
    bus.b_valid = v; bus.b_addr = ad; bus.b_data = d; bus.b_pc = p;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_we"}, 32'(bus.WE), 0);
    chk({tag, "_a3"}, 32'(bus.A3), 0);
    chk({tag, "_pend"}, bus.pend_mask, 0);
    chk({tag, "_rdy"}, 32'(bus.b_ready), 1);
    chk({tag, "_stv"}, 32'(bus.starve_req), 0);
  endtask
  initial begin
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    tick(); tick();
    chk_idle("rst0");
    reset = 1'b0;
    // A only
    drv_a(1, 8, 32'h12345678, 32'h3000);
    tick();
    chk("a_we", 32'(bus.WE), 1);
    chk("a_a3", 32'(bus.A3), 8);
    chk("a_wd", bus.WD, 32'h12345678);
    chk("a_pc", bus.PC, 32'h3000);
    drv_a(1, 0, 32'h5555, 32'h3004);
    tick();
    chk("a0_we", 32'(bus.WE), 0);
    chk("a0_hold", 32'(bus.A3), 8);
    // B queued behind A writes to $5..$7
    drv_a(1, 5, 32'h5, 32'h100);
    drv_b(1, 9, 32'hDEAD, 32'h3004);
    tick();
    drv_b(0, 0, 0, 0);
    chk("q_pend1", bus.pend_mask, 32'h200);
    chk("q_a3_5", 32'(bus.A3), 5);
    drv_a(1, 6, 32'h6, 32'h104);
    tick();
    chk("q_pend2", bus.pend_mask, 32'h200);
    drv_a(1, 7, 32'h7, 32'h108);
    tick();
    chk("q_pend3", bus.pend_mask, 32'h200);
    chk("q_a3_7", 32'(bus.A3), 7);
    drv_a(0, 0, 0, 0);
    tick();
    chk("q_we", 32'(bus.WE), 1);
    chk("q_a3", 32'(bus.A3), 9);
    chk("q_wd", bus.WD, 32'hDEAD);
    chk("q_pc", bus.PC, 32'h3004);
    chk("q_pend0", bus.pend_mask, 0);
    // full / backpressure
    drv_a(1, 1, 32'h1, 32'h200);
    drv_b(1, 10, 32'hA0, 32'h400);
    tick();
    chk("f_rdy1", 32'(bus.b_ready), 1);
    drv_b(1, 11, 32'hB0, 32'h404);
    tick();
    chk("f_rdy0", 32'(bus.b_ready), 0);
    drv_a(1, 2, 32'h2, 32'h204);
    drv_b(1, 13, 32'hC0, 32'h408);
    tick();
    chk("f_rdy_hold", 32'(bus.b_ready), 0);
    chk("f_pend", bus.pend_mask, 32'h0C00);
    drv_a(0, 0, 0, 0);
    tick();
    chk("f_w1_we", 32'(bus.WE), 1);
    chk("f_w1_a3", 32'(bus.A3), 10);
    chk("f_w1_wd", bus.WD, 32'hA0);
    chk("f_pend1", bus.pend_mask, 32'h0800);
    tick();
    chk("f_w2_a3", 32'(bus.A3), 11);
    chk("f_pend2", bus.pend_mask, 32'h2000);
    drv_b(0, 0, 0, 0);
    tick();
    chk("f_w3_a3", 32'(bus.A3), 13);
    chk("f_w3_wd", bus.WD, 32'hC0);
    chk("f_w3_pc", bus.PC, 32'h408);
    tick();
    chk("f_idle_we", 32'(bus.WE), 0);
    // WAW squash of an older queued B
    drv_a(1, 3, 32'h3, 32'h300);
    drv_b(1, 12, 32'h1, 32'h500);
    tick();
    drv_b(0, 0, 0, 0);
    chk("s_pend", bus.pend_mask, 32'h1000);
    drv_a(1, 12, 32'h2, 32'h304);
    tick();
    chk("s_pend0", bus.pend_mask, 0);
    chk("s_a3", 32'(bus.A3), 12);
    chk("s_wd", bus.WD, 32'h2);
    drv_a(0, 0, 0, 0);
    tick();
    chk("s_nowr", 32'(bus.WE), 0);
    tick();
    chk("s_nowr2", 32'(bus.WE), 0);
    chk("s_wd_hold", bus.WD, 32'h2);
    // same-cycle push to the A register survives
    drv_a(1, 14, 32'h41, 32'h308);
    drv_b(1, 14, 32'h14, 32'h504);
    tick();
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    chk("y_pend", bus.pend_mask, 32'h4000);
    chk("y_wd_a", bus.WD, 32'h41);
    tick();
    chk("y_we", 32'(bus.WE), 1);
    chk("y_wd_b", bus.WD, 32'h14);
    // b_addr=0 is accepted but never queued
    drv_b(1, 0, 32'hFF, 32'h600);
    tick();
    drv_b(0, 0, 0, 0);
    chk("z_pend", bus.pend_mask, 0);
    chk("z_rdy", 32'(bus.b_ready), 1);
    tick();
    chk("z_we", 32'(bus.WE), 0);
    // starvation
    drv_a(1, 4, 32'h4, 32'h700);
    drv_b(1, 15, 32'hF15, 32'h800);
    tick();
    drv_b(1, 16, 32'hF16, 32'h804);
    tick();
    drv_b(0, 0, 0, 0);
    tick(); tick(); tick();
    chk("st_3", 32'(bus.starve_req), 0);
    tick();
    chk("st_4", 32'(bus.starve_req), 1);
    tick();
    chk("st_sat", 32'(bus.starve_req), 1);
    chk("st_a_we", 32'(bus.WE), 1);
    chk("st_a_a3", 32'(bus.A3), 4);
    drv_a(0, 0, 0, 0);
    tick();
    chk("st_pop_a3", 32'(bus.A3), 15);
    chk("st_clr", 32'(bus.starve_req), 0);
    tick();
    chk("st_pop2", 32'(bus.A3), 16);
    // reset mid-traffic
    drv_a(1, 18, 32'h18, 32'h900);
    drv_b(1, 17, 32'h17, 32'hA00);
    tick();
    chk("r_pre", bus.pend_mask, 32'h20000);
    reset = 1'b1;
    #1;
    chk_idle("r_async");
    tick(); tick(); tick();
    chk_idle("r_held");
    reset = 1'b0;
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    tick();
    chk_idle("r_after");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
